gdb_rsp_rx_ctrl: RTL and testbench
==================================

Name: gdb_rsp_rx_ctrl

Overview:
Receive-side controller for the GDB Remote Serial Protocol byte stream delivered by the socket layer. It frames `$payload#hh` packets, unescapes the payload, verifies the mod-256 checksum, stores the payload in an internal buffer and issues the `+`/`-` acknowledge byte. It also detects the out-of-band break character. It sits between the socket byte stream (in and out) and the stub command decoder.

Parameters:
BUF_LEN, 256, payload buffer depth in bytes.
LW, $clog2(BUF_LEN+1), width of the length and address fields.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_vld  in  1  inbound byte valid
rx_rdy  out  1  inbound byte ready
rx_dat  in  8  inbound byte
tx_vld  out  1  ack byte valid
tx_rdy  in  1  ack byte ready
tx_dat  out  8  ack byte (0x2B `+` or 0x2D `-`)
no_ack  in  1  no-ack mode: suppress ack bytes (QStartNoAckMode)
pkt_vld  out  1  complete verified packet available
pkt_rdy  in  1  consumer releases packet
pkt_len  out  LW  unescaped payload length
rd_adr  in  LW  buffer read address
rd_dat  out  8  buffer read data, registered, 1-cycle latency
brk  out  1  one-cycle pulse on 0x03 received in IDLE
err_cnt  out  8  saturating count of rejected packets

Behaviour:
- Reset values: rx_rdy=0, tx_vld=0, tx_dat=0x2B, pkt_vld=0, pkt_len=0, rd_dat=0, brk=0, err_cnt=0. State=IDLE. Reset mid-packet discards the partial packet; buffer contents are undefined.
- A byte transfers when rx_vld&&rx_rdy. An ack transfers when tx_vld&&tx_rdy. A packet is released when pkt_vld&&pkt_rdy.
- rx_rdy=1 in IDLE, DATA, ESC, CS_HI and CS_LO; 0 in ACK and DONE.
- IDLE:
  - `$` (0x24): clear sum, len and ovf; go to DATA.
  - 0x03: brk=1 for the next cycle only; stay in IDLE.
  - Any other byte (including `+`, `-`) is dropped.
- DATA:
  - `#` (0x23): go to CS_HI.
  - `$`: restart the packet (clear sum, len, ovf); stay in DATA.
  - `}` (0x7D): sum+=byte; go to ESC.
  - Other byte: sum+=byte; store the byte.
- ESC: sum+=byte; store byte^0x20; go to DATA. A `#` or `$` received here is treated as data.
- Store rule: if len<BUF_LEN, write buf[len] and len++. Otherwise set ovf and do not write.
- Sum is 8 bits and wraps mod 256. It is computed over raw bytes between `$` and `#`, escape characters included.
- CS_HI, CS_LO: each accepts one hex digit (0-9, a-f, A-F) to build an 8-bit checksum, upper nibble first. A non-hex digit sets bad. After CS_LO: ok = !bad && !ovf && (cs==sum).
- ACK:
  - no_ack=0: tx_vld=1 with tx_dat = ok ? 0x2B : 0x2D, held until tx_rdy. On the transfer: go to DONE if ok, else increment err_cnt (saturating at 255) and go to IDLE.
  - no_ack=1: ACK takes 1 cycle with no tx. ok goes to DONE; !ok increments err_cnt and goes to IDLE.
- DONE: pkt_vld=1 and pkt_len=len are held stable until pkt_rdy. Then go to IDLE; pkt_vld drops the next cycle.
- Latency: pkt_vld rises the cycle after the ack transfer. In no-ack mode it rises 2 cycles after the last checksum digit is accepted.
- Empty packet `$#00` is valid: pkt_len=0.
- rd_dat = buf[rd_adr] registered every cycle. Out-of-range addresses return an undefined value.
- no_ack is sampled at entry to ACK.

Test Plan:
- Stream `$g#67` with tx_rdy=1 -> tx_dat=0x2B once; pkt_vld=1, pkt_len=1, rd_adr=0 gives rd_dat=0x67; pkt_rdy -> IDLE; err_cnt=0.
- Stream `$g#00` -> tx_dat=0x2D; no pkt_vld; err_cnt=1. Then stream `$g#6z` -> 0x2D; err_cnt=2.
- Stream `$}]#da` -> checksum ok (0x7D+0x5D=0xDA); pkt_len=1, buf[0]=0x7D, ack 0x2B.
- With BUF_LEN=4, stream `$abcde#ef` -> sum 0xEF matches but ovf set -> 0x2D, no pkt_vld, err_cnt=1.
- In IDLE, bytes 0x2B, 0x03, 0x2D -> brk pulses exactly one cycle after the 0x03 transfer; no tx activity; state remains IDLE.
- With no_ack=1, stream `$g#67` while holding pkt_rdy=0 for 5 cycles, then a second `$m#6d` -> no tx_vld ever; pkt_vld held with rx_rdy=0 during the hold; the second packet is accepted only after release, with pkt_len=1 and buf[0]=0x6D. Also assert rst mid-packet (`$ab`) -> next `$g#67` yields a correct packet.

Source files
------------

// File: rtl/gdb_rsp_rx_ctrl.sv
// GDB Remote Serial Protocol receive controller: frames $payload#hh packets,
// unescapes and buffers the payload, checks the checksum and issues +/- acks.
module gdb_rsp_rx_ctrl #(
    parameter int BUF_LEN = 256,
    parameter int LW      = $clog2(BUF_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_vld,
    output logic          rx_rdy,
    input  logic [7:0]    rx_dat,
    output logic          tx_vld,
    input  logic          tx_rdy,
    output logic [7:0]    tx_dat,
    input  logic          no_ack,
    output logic          pkt_vld,
    input  logic          pkt_rdy,
    output logic [LW-1:0] pkt_len,
    input  logic [LW-1:0] rd_adr,
    output logic [7:0]    rd_dat,
    output logic          brk,
    output logic [7:0]    err_cnt
);

    localparam int            AW      = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam logic [LW-1:0] BUF_MAX = LW'(BUF_LEN);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_ESC    = 8'h7D;
    localparam logic [7:0] CH_BRK    = 8'h03;
    localparam logic [7:0] CH_ACK    = 8'h2B;
    localparam logic [7:0] CH_NAK    = 8'h2D;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ESC,
        CS_HI,
        CS_LO,
        ACK,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    sum;
    logic [3:0]    cs_hi;
    logic [LW-1:0] len;
    logic          ovf;
    logic          bad;
    logic          ok;
    logic          ack_off;
    logic [7:0]    mem [BUF_LEN];

    logic          rx_fire;
    logic          tx_fire;
    logic          hex_ok;
    logic [3:0]    hex_val;
    logic          store;
    logic          room;
    logic [7:0]    wr_dat;
    logic          cs_good;

    assign rx_fire = rx_vld && rx_rdy;
    assign tx_fire = tx_vld && tx_rdy;

    // Letters a-f and A-F share their low nibble 1..6, so +9 maps them to 10..15.
    always_comb begin
        hex_ok  = 1'b1;
        hex_val = 4'd0;
        if (rx_dat >= 8'h30 && rx_dat <= 8'h39) begin
            hex_val = rx_dat[3:0];
        end else if ((rx_dat >= 8'h61 && rx_dat <= 8'h66) ||
                     (rx_dat >= 8'h41 && rx_dat <= 8'h46)) begin
            hex_val = rx_dat[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
    end

    always_comb begin
        store   = rx_fire && ((state == DATA && rx_dat != CH_HASH &&
                               rx_dat != CH_DOLLAR && rx_dat != CH_ESC) ||
                              state == ESC);
        room    = len < BUF_MAX;
        wr_dat  = (state == ESC) ? (rx_dat ^ 8'h20) : rx_dat;
        cs_good = !bad && hex_ok && !ovf && ({cs_hi, hex_val} == sum);
    end

    always_ff @(posedge clk) begin
        if (store && room) begin
            mem[len[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat <= 8'h00;
        end else if (rd_adr < BUF_MAX) begin
            rd_dat <= mem[rd_adr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rx_rdy  <= 1'b0;
            tx_vld  <= 1'b0;
            tx_dat  <= CH_ACK;
            pkt_vld <= 1'b0;
            pkt_len <= '0;
            brk     <= 1'b0;
            err_cnt <= 8'h00;
            sum     <= 8'h00;
            cs_hi   <= 4'h0;
            len     <= '0;
            ovf     <= 1'b0;
            bad     <= 1'b0;
            ok      <= 1'b0;
            ack_off <= 1'b0;
        end else begin
            brk <= 1'b0;
            if (store) begin
                if (room) begin
                    len <= len + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    rx_rdy <= 1'b1;
                    if (rx_fire) begin
                        if (rx_dat == CH_DOLLAR) begin
                            sum   <= 8'h00;
                            len   <= '0;
                            ovf   <= 1'b0;
                            bad   <= 1'b0;
                            state <= DATA;
                        end else if (rx_dat == CH_BRK) begin
                            brk <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        if (rx_dat == CH_HASH) begin
                            state <= CS_HI;
                        end else if (rx_dat == CH_DOLLAR) begin
                            sum <= 8'h00;
                            len <= '0;
                            ovf <= 1'b0;
                            bad <= 1'b0;
                        end else begin
                            sum <= sum + rx_dat;
                            if (rx_dat == CH_ESC) begin
                                state <= ESC;
                            end
                        end
                    end
                end
                ESC: begin
                    if (rx_fire) begin
                        sum   <= sum + rx_dat;
                        state <= DATA;
                    end
                end
                CS_HI: begin
                    if (rx_fire) begin
                        cs_hi <= hex_val;
                        bad   <= !hex_ok;
                        state <= CS_LO;
                    end
                end
                CS_LO: begin
                    if (rx_fire) begin
                        ok      <= cs_good;
                        ack_off <= no_ack;
                        rx_rdy  <= 1'b0;
                        state   <= ACK;
                        if (!no_ack) begin
                            tx_vld <= 1'b1;
                            tx_dat <= cs_good ? CH_ACK : CH_NAK;
                        end
                    end
                end
                ACK: begin
                    if (ack_off || tx_fire) begin
                        tx_vld <= 1'b0;
                        if (ok) begin
                            pkt_vld <= 1'b1;
                            pkt_len <= len;
                            state   <= DONE;
                        end else begin
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'h01;
                            end
                            rx_rdy <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (pkt_rdy) begin
                        pkt_vld <= 1'b0;
                        rx_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gdb_rsp_rx_ctrl.sv
// Scoreboard bench for gdb_rsp_rx_ctrl: stimulus pushes expected acks and
// packets into queues, independent monitors pop and compare them.
module tb_gdb_rsp_rx_ctrl;

    localparam int BUF_LEN = 4;
    localparam int LW      = $clog2(BUF_LEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_vld;
    logic          rx_rdy;
    logic [7:0]    rx_dat;
    logic          tx_vld;
    logic          tx_rdy;
    logic [7:0]    tx_dat;
    logic          no_ack;
    logic          pkt_vld;
    logic          pkt_rdy;
    logic [LW-1:0] pkt_len;
    logic [LW-1:0] rd_adr;
    logic [7:0]    rd_dat;
    logic          brk;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad = 0;
    int brk_seen = 0;
    int hold = 0;
    logic mon_busy = 1'b0;

    logic [7:0] ack_q [$];
    int         len_q [$];
    logic [7:0] byte_q [$];

    gdb_rsp_rx_ctrl #(.BUF_LEN(BUF_LEN)) dut (
        .clk(clk), .rst(rst),
        .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_dat(rx_dat),
        .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_dat(tx_dat),
        .no_ack(no_ack),
        .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len),
        .rd_adr(rd_adr), .rd_dat(rd_dat),
        .brk(brk), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expectPkt(input string p);
        len_q.push_back(p.len());
        for (int i = 0; i < p.len(); i++) byte_q.push_back(p[i]);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        rx_vld = 1'b1;
        rx_dat = b;
        while (!rx_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checkOutput("rx_rdy_timeout", 32'(rx_rdy), 32'd1);
            rx_vld = 1'b0;
            return;
        end
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((ack_q.size() != 0 || len_q.size() != 0 || mon_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) checkOutput("drain_timeout", 32'(ack_q.size() + len_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Ack-side ready toggles off every third cycle so the held tx_vld path is exercised.
    initial begin
        int cyc = 0;
        tx_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            tx_rdy = (cyc % 3 != 0);
        end
    end

    always @(negedge clk) begin
        if (brk) brk_seen++;
    end

    always @(negedge clk) begin
        if (!rst && tx_vld && tx_rdy) begin
            if (ack_q.size() == 0) begin
                checkOutput("unexpected_ack", 32'(tx_dat), 32'hFFFF);
            end else begin
                checkOutput("ack_byte", 32'(tx_dat), 32'(ack_q.pop_front()));
            end
        end
    end

    // Packet monitor owns rd_adr and pkt_rdy: reads back the buffer, then releases.
    initial begin
        int elen;
        pkt_rdy = 1'b0;
        rd_adr  = '0;
        forever begin
            @(negedge clk);
            if (!rst && pkt_vld) begin
                mon_busy = 1'b1;
                if (len_q.size() == 0) begin
                    checkOutput("unexpected_pkt", 32'(pkt_len), 32'hFFFF);
                    elen = 0;
                end else begin
                    elen = len_q.pop_front();
                    checkOutput("pkt_len", 32'(pkt_len), 32'(elen));
                end
                for (int h = 0; h < hold; h++) begin
                    checkOutput("hold_pkt_vld", 32'(pkt_vld), 32'd1);
                    checkOutput("hold_rx_rdy", 32'(rx_rdy), 32'd0);
                    @(negedge clk);
                end
                for (int i = 0; i < elen; i++) begin
                    rd_adr = LW'(i);
                    @(negedge clk);
                    checkOutput("rd_dat", 32'(rd_dat), 32'(byte_q.pop_front()));
                end
                pkt_rdy = 1'b1;
                @(negedge clk);
                pkt_rdy = 1'b0;
                checkOutput("pkt_vld_drop", 32'(pkt_vld), 32'd0);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int brk_base;
        rst    = 1'b1;
        rx_vld = 1'b0;
        rx_dat = 8'h00;
        no_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        checkOutput("rst_tx_vld", 32'(tx_vld), 32'd0);
        checkOutput("rst_tx_dat", 32'(tx_dat), 32'h2B);
        checkOutput("rst_pkt_vld", 32'(pkt_vld), 32'd0);
        checkOutput("rst_pkt_len", 32'(pkt_len), 32'd0);
        checkOutput("rst_rd_dat", 32'(rd_dat), 32'd0);
        checkOutput("rst_brk", 32'(brk), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic good packet");
        ack_q.push_back(8'h2B); expectPkt("g");
        applyStimulus("$g#67"); waitDrain();
        checkOutput("err_cnt_good", 32'(err_cnt), 32'd0);

        $display("[TB] bad checksum and bad hex digit");
        ack_q.push_back(8'h2D);
        applyStimulus("$g#00"); waitDrain();
        checkOutput("err_cnt_badcs", 32'(err_cnt), 32'd1);
        ack_q.push_back(8'h2D);
        applyStimulus("$g#6z"); waitDrain();
        checkOutput("err_cnt_badhex", 32'(err_cnt), 32'd2);

        $display("[TB] escape, overflow, full buffer, empty, restart");
        ack_q.push_back(8'h2B); expectPkt("}");
        applyStimulus("$}]#da"); waitDrain();
        ack_q.push_back(8'h2D);
        applyStimulus("$abcde#ef"); waitDrain();
        checkOutput("err_cnt_ovf", 32'(err_cnt), 32'd3);
        ack_q.push_back(8'h2B); expectPkt("abcd");
        applyStimulus("$abcd#8A"); waitDrain();
        ack_q.push_back(8'h2B); expectPkt("");
        applyStimulus("$#00"); waitDrain();
        ack_q.push_back(8'h2B); expectPkt("g");
        applyStimulus("$xx$g#67"); waitDrain();
        checkOutput("err_cnt_after", 32'(err_cnt), 32'd3);

        $display("[TB] break detection in idle");
        brk_base = brk_seen;
        sendByte(8'h2B);
        sendByte(8'h03);
        checkOutput("brk_pulse", 32'(brk), 32'd1);
        sendByte(8'h2D);
        repeat (2) @(negedge clk);
        checkOutput("brk_count", 32'(brk_seen - brk_base), 32'd1);
        checkOutput("brk_idle_rdy", 32'(rx_rdy), 32'd1);
        checkOutput("brk_no_tx", 32'(tx_vld), 32'd0);

        $display("[TB] no-ack mode with held packet");
        no_ack = 1'b1;
        hold   = 5;
        expectPkt("g"); expectPkt("m");
        applyStimulus("$g#6");
        sendByte("7");
        checkOutput("noack_lat_ack", 32'(pkt_vld), 32'd0);
        @(negedge clk);
        checkOutput("noack_lat_done", 32'(pkt_vld), 32'd1);
        applyStimulus("$m#6d"); waitDrain();
        applyStimulus("$g#00"); waitDrain();
        checkOutput("err_cnt_noack", 32'(err_cnt), 32'd4);
        hold   = 0;
        no_ack = 1'b0;

        $display("[TB] reset mid-packet");
        applyStimulus("$ab");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("err_cnt_rst", 32'(err_cnt), 32'd0);
        ack_q.push_back(8'h2B); expectPkt("g");
        applyStimulus("$g#67"); waitDrain();

        $display("[TB] error counter saturation");
        no_ack = 1'b1;
        for (int i = 0; i < 255; i++) applyStimulus("$#01");
        repeat (3) @(negedge clk);
        checkOutput("err_cnt_255", 32'(err_cnt), 32'd255);
        applyStimulus("$#01");
        repeat (3) @(negedge clk);
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'd255);
        no_ack = 1'b0;

        checkOutput("ack_q_left", 32'(ack_q.size()), 32'd0);
        checkOutput("pkt_q_left", 32'(len_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
